// File: rtl/timer_pkg.sv
// Shared types and helpers for the prescaled timer controller and its divider chain.
package timer_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      EXPIRED = 2'd2
   } state_t;

   // Widest prescaler the mask helper can describe.
   localparam int MAX_STAGES = 32;

   function automatic int tap_width(input int stages);
      return (stages < 1) ? 1 : $clog2(stages + 1);
   endfunction

   // All-ones mask covering the low 'tap' bits of the prescaler count.
   function automatic logic [MAX_STAGES-1:0] tap_mask(input int tap);
      logic [MAX_STAGES-1:0] m;
      m = '0;
      for (int i = 0; i < MAX_STAGES; i++) begin
         if (i < tap) m[i] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Enable-gated binary divider chain; tick fires when the low tap bits of pc are all ones.
module timer_prescaler
   import timer_pkg::*;
#(
   parameter  int DIV_STAGES = 8,
   localparam int TAP_W      = tap_width(DIV_STAGES)
) (
   input  logic                  clk,
   input  logic                  arst,
   input  logic                  en,
   input  logic                  clr,
   input  logic [TAP_W-1:0]      tap,
   output logic [DIV_STAGES-1:0] pc,
   output logic                  tick
);

   logic [DIV_STAGES-1:0] mask;

   assign mask = DIV_STAGES'(tap_mask(int'(tap)));

   // Clear has priority so a restart always begins a fresh prescale period.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         pc <= '0;
      end else if (clr) begin
         pc <= '0;
      end else if (en) begin
         pc <= pc + DIV_STAGES'(1);
      end
   end

   assign tick = en && ((pc & mask) == mask);

endmodule

// File: rtl/prescale_timer_ctrl.sv
// Programmable timer controller: shadow config, IDLE/RUN/EXPIRED sequencing and the reload down-counter.
module prescale_timer_ctrl
   import timer_pkg::*;
#(
   parameter  int DIV_STAGES = 8,
   parameter  int CNT_W      = 16,
   localparam int TAP_W      = tap_width(DIV_STAGES)
) (
   input  logic             clk,
   input  logic             arst,
   input  logic             cfg_wr,
   input  logic [TAP_W-1:0] cfg_tap,
   input  logic [CNT_W-1:0] cfg_load,
   input  logic             cfg_periodic,
   input  logic             start,
   input  logic             stop,
   input  logic             ack,
   output logic             tick,
   output logic [CNT_W-1:0] count,
   output logic             busy,
   output logic             expired,
   output logic             irq
);

   localparam logic [TAP_W-1:0] MAX_TAP = TAP_W'(DIV_STAGES);

   state_t             state, state_n;
   logic [TAP_W-1:0]   shadow_tap;
   logic [CNT_W-1:0]   shadow_load;
   logic               shadow_periodic;
   logic [TAP_W-1:0]   run_tap, run_tap_n;
   logic               run_periodic, run_periodic_n;
   logic [CNT_W-1:0]   count_n;
   logic               expired_n;
   logic               irq_n;
   logic               run_en;
   logic               pc_clr;
   logic               launch;
   logic               expiry;
   logic [DIV_STAGES-1:0] pc_unused;

   // Shadow registers only feed the next start or reload, never the period in flight.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         shadow_tap      <= '0;
         shadow_load     <= '0;
         shadow_periodic <= 1'b0;
      end else if (cfg_wr) begin
         shadow_tap      <= (cfg_tap > MAX_TAP) ? MAX_TAP : cfg_tap;
         shadow_load     <= cfg_load;
         shadow_periodic <= cfg_periodic;
      end
   end

   assign launch = start && (shadow_load != '0);
   assign run_en = (state == RUN);
   assign pc_clr = (state != RUN) || stop || launch;
   assign busy   = run_en;

   timer_prescaler #(
      .DIV_STAGES(DIV_STAGES)
   ) u_prescaler (
      .clk (clk),
      .arst(arst),
      .en  (run_en),
      .clr (pc_clr),
      .tap (run_tap),
      .pc  (pc_unused),
      .tick(tick)
   );

   assign expiry = run_en && tick && (count == CNT_W'(1));

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state        <= IDLE;
         count        <= '0;
         expired      <= 1'b0;
         irq          <= 1'b0;
         run_tap      <= '0;
         run_periodic <= 1'b0;
      end else begin
         state        <= state_n;
         count        <= count_n;
         expired      <= expired_n;
         irq          <= irq_n;
         run_tap      <= run_tap_n;
         run_periodic <= run_periodic_n;
      end
   end

   // Stop outranks restart and expiry, but an expiry on that edge still raises irq.
   always_comb begin
      state_n        = state;
      count_n        = count;
      expired_n      = expired;
      irq_n          = 1'b0;
      run_tap_n      = run_tap;
      run_periodic_n = run_periodic;
      case (state)
         IDLE: begin
            if (launch) begin
               state_n        = RUN;
               count_n        = shadow_load;
               run_tap_n      = shadow_tap;
               run_periodic_n = shadow_periodic;
            end
         end
         RUN: begin
            irq_n = expiry;
            if (stop) begin
               state_n = IDLE;
            end else if (launch) begin
               count_n        = shadow_load;
               run_tap_n      = shadow_tap;
               run_periodic_n = shadow_periodic;
            end else if (expiry) begin
               if (run_periodic && (shadow_load != '0)) begin
                  count_n = shadow_load;
               end else begin
                  count_n   = '0;
                  state_n   = EXPIRED;
                  expired_n = 1'b1;
               end
            end else if (tick && (count != '0)) begin
               count_n = count - CNT_W'(1);
            end
         end
         EXPIRED: begin
            if (launch) begin
               state_n        = RUN;
               count_n        = shadow_load;
               expired_n      = 1'b0;
               run_tap_n      = shadow_tap;
               run_periodic_n = shadow_periodic;
            end else if (ack) begin
               state_n   = IDLE;
               expired_n = 1'b0;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_prescale_timer_ctrl.sv
// Scoreboard bench for prescale_timer_ctrl: expected interrupts are queued at start, a monitor pops them on irq.
module tb_prescale_timer_ctrl;

   logic        clk = 1'b0;
   logic        arst;
   logic        cfg_wr;
   logic [3:0]  cfg_tap;
   logic [15:0] cfg_load;
   logic        cfg_periodic;
   logic        start;
   logic        stop;
   logic        ack;
   logic        tick;
   logic [15:0] count;
   logic        busy;
   logic        expired;
   logic        irq;

   typedef struct {
      int          cyc;
      logic [15:0] cnt;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   k;

   prescale_timer_ctrl #(
      .DIV_STAGES(8),
      .CNT_W(16)
   ) dut (
      .clk         (clk),
      .arst        (arst),
      .cfg_wr      (cfg_wr),
      .cfg_tap     (cfg_tap),
      .cfg_load    (cfg_load),
      .cfg_periodic(cfg_periodic),
      .start       (start),
      .stop        (stop),
      .ack         (ack),
      .tick        (tick),
      .count       (count),
      .busy        (busy),
      .expired     (expired),
      .irq         (irq)
   );

   always #5 clk = ~clk;

   // Edge counter: during the cycle after rising edge n, cyc reads n.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   function automatic void expectIrq(input int c, input int cnt);
      exp_t e;
      e.cyc = c;
      e.cnt = cnt[15:0];
      sb.push_back(e);
   endfunction

   // Called at a falling edge; the pulse is sampled by the next rising edge.
   task automatic applyStimulus(input logic s, input logic p, input logic a);
      start = s;
      stop  = p;
      ack   = a;
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      ack   = 1'b0;
   endtask

   task automatic cfgWrite(input int tap, input int load, input logic periodic);
      cfg_tap      = tap[3:0];
      cfg_load     = load[15:0];
      cfg_periodic = periodic;
      cfg_wr       = 1'b1;
      @(negedge clk);
      cfg_wr = 1'b0;
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Monitor: every irq pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!arst && irq) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL irq_unexpected: got irq=1 expected none (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            checkOutput("irq_cycle", cyc, e.cyc);
            checkOutput("irq_count", int'(count), int'(e.cnt));
         end
      end
   end

   initial begin
      arst = 1'b1; cfg_wr = 1'b0; cfg_tap = '0; cfg_load = '0; cfg_periodic = 1'b0;
      start = 1'b0; stop = 1'b0; ack = 1'b0;
      waitCycles(3);
      checkOutput("rst_count", int'(count), 0);
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_expired", int'(expired), 0);
      checkOutput("rst_irq", int'(irq), 0);
      checkOutput("rst_tick", int'(tick), 0);
      arst = 1'b0;
      waitCycles(1);

      $display("[TB] one-shot tap=2 load=3");
      cfgWrite(2, 3, 1'b0);
      k = cyc + 1;
      expectIrq(k + 12, 0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 12; i++) begin
         checkOutput("t1_tick", int'(tick), (i % 4 == 3) ? 1 : 0);
         checkOutput("t1_count", int'(count), 3 - i / 4);
         checkOutput("t1_busy", int'(busy), 1);
         waitCycles(1);
      end
      checkOutput("t1_exp_count", int'(count), 0);
      checkOutput("t1_exp_flag", int'(expired), 1);
      checkOutput("t1_exp_busy", int'(busy), 0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("t1_ack_flag", int'(expired), 0);
      checkOutput("t1_ack_busy", int'(busy), 0);

      $display("[TB] periodic tap=0 load=5 then stop");
      cfgWrite(0, 5, 1'b1);
      k = cyc + 1;
      for (int j = 1; j <= 4; j++) expectIrq(k + 5 * j, 5);
      applyStimulus(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 22; i++) begin
         checkOutput("t2_busy", int'(busy), 1);
         if (i % 5 == 0) checkOutput("t2_reload", int'(count), 5);
         waitCycles(1);
      end
      checkOutput("t2_count_prestop", int'(count), 3);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("t2_stop_busy", int'(busy), 0);
      checkOutput("t2_stop_count", int'(count), 3);
      waitCycles(10);
      checkOutput("t2_frozen_count", int'(count), 3);
      checkOutput("t2_idle_tick", int'(tick), 0);

      $display("[TB] zero load start and clamped tap");
      cfgWrite(1, 0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("t3_zero_busy", int'(busy), 0);
      waitCycles(4);
      checkOutput("t3_zero_tick", int'(tick), 0);
      checkOutput("t3_zero_count", int'(count), 3);
      cfgWrite(11, 1, 1'b0);
      k = cyc + 1;
      expectIrq(k + 256, 0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      waitCycles(254);
      checkOutput("t3_clamp_notick", int'(tick), 0);
      checkOutput("t3_clamp_count", int'(count), 1);
      waitCycles(1);
      checkOutput("t3_clamp_tick", int'(tick), 1);
      waitCycles(1);
      checkOutput("t3_clamp_expired", int'(expired), 1);
      applyStimulus(1'b0, 1'b0, 1'b1);

      $display("[TB] mid-run reload change, start+stop");
      cfgWrite(1, 4, 1'b1);
      k = cyc + 1;
      expectIrq(k + 8, 2);
      expectIrq(k + 12, 2);
      expectIrq(k + 16, 2);
      applyStimulus(1'b1, 1'b0, 1'b0);
      waitCycles(3);
      cfgWrite(3, 2, 1'b1);
      checkOutput("t4_first_period", int'(count), 2);
      waitCycles(13);
      checkOutput("t4_count_k17", int'(count), 2);
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("t4_startstop_busy", int'(busy), 0);
      checkOutput("t4_startstop_count", int'(count), 2);
      waitCycles(6);
      checkOutput("t4_idle_tick", int'(tick), 0);

      $display("[TB] async reset mid-run");
      cfgWrite(0, 10, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0);
      waitCycles(3);
      #2 arst = 1'b1;
      #1;
      checkOutput("t5_arst_count", int'(count), 0);
      checkOutput("t5_arst_busy", int'(busy), 0);
      checkOutput("t5_arst_tick", int'(tick), 0);
      checkOutput("t5_arst_irq", int'(irq), 0);
      checkOutput("t5_arst_expired", int'(expired), 0);
      @(negedge clk);
      arst = 1'b0;
      waitCycles(15);
      checkOutput("t5_post_busy", int'(busy), 0);
      checkOutput("t5_post_count", int'(count), 0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("t5_shadow_cleared", int'(busy), 0);

      $display("[TB] expiry with ack, expiry with stop");
      cfgWrite(0, 3, 1'b0);
      k = cyc + 1;
      expectIrq(k + 3, 0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      waitCycles(2);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("t6_ack_expired", int'(expired), 1);
      checkOutput("t6_ack_busy", int'(busy), 0);
      checkOutput("t6_ack_irq", int'(irq), 1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("t6_ack_clear", int'(expired), 0);
      cfgWrite(0, 2, 1'b0);
      k = cyc + 1;
      expectIrq(k + 2, 1);
      applyStimulus(1'b1, 1'b0, 1'b0);
      waitCycles(1);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("t6_stop_busy", int'(busy), 0);
      checkOutput("t6_stop_expired", int'(expired), 0);
      checkOutput("t6_stop_count", int'(count), 1);

      waitCycles(5);
      checkOutput("irq_pending", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/prescale_timer_ctrl.md
Name: prescale_timer_ctrl

Overview:
- Controller that sequences a binary divide-by-2^k prescaler and a down-counter to form a programmable timer.
- Software-style config is captured into shadow registers. Start/stop/ack control a three-state FSM.
- Outputs are a prescaled tick enable, a one-cycle expiry interrupt, and status.
- Sits between the register interface and the divider chain; it owns when the divider runs and which tap is used.

Parameters:
- DIV_STAGES, 8, number of divide-by-2 prescaler stages; legal tap range 0..DIV_STAGES.
- CNT_W, 16, width of the reload value and down-counter.
- TAP_W, $clog2(DIV_STAGES+1), width of the tap select (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- arst  in  1  asynchronous, active-high reset.
- cfg_wr  in  1  capture cfg_tap/cfg_load/cfg_periodic into shadow registers.
- cfg_tap  in  TAP_W  prescale select; tick period = 2^cfg_tap cycles; values above DIV_STAGES are clamped to DIV_STAGES.
- cfg_load  in  CNT_W  reload value N (ticks per expiry).
- cfg_periodic  in  1  1 = auto-reload, 0 = one-shot.
- start  in  1  single-cycle start/restart request.
- stop  in  1  single-cycle stop request.
- ack  in  1  clears expired flag.
- tick  out  1  prescaled enable, high one cycle per 2^tap cycles while RUN.
- count  out  CNT_W  current down-counter value.
- busy  out  1  high in RUN.
- expired  out  1  sticky one-shot completion flag.
- irq  out  1  one-cycle pulse on every expiry.

Behaviour:
- Reset (arst=1, async): state IDLE; count=0; busy=0; expired=0; irq=0; tick=0; prescaler pc=0; shadow load=0, tap=0, periodic=0.
- Shadow config:
  - cfg_wr is accepted in any state.
  - New tap is used from the next start.
  - New load is used from the next start or the next periodic reload.
  - Running timing is never disturbed.
- FSM states IDLE, RUN, EXPIRED. Requests are sampled at the rising edge.
- IDLE:
  - start with shadow load != 0 → RUN; count<=load; pc<=0.
  - start with load == 0 is ignored; the FSM stays in IDLE.
- RUN:
  - pc (DIV_STAGES bits) increments every cycle.
  - tick = RUN && pc[tap-1:0] all ones; tap=0 gives tick every cycle.
  - On tick, count decrements.
- Expiry is a tick with count==1, and is a single edge:
  - periodic: count<=shadow load, stay RUN, pc keeps running.
  - one-shot: count<=0, → EXPIRED, expired<=1, busy<=0.
  - In both modes irq<=1 for exactly that next cycle.
- Latency: start accepted at edge k, load N, tap t → irq high in the cycle following edge k + N*2^t. Example: N=3, t=2 → 12 cycles.
- stop in RUN → IDLE. count is frozen at its current value, pc is cleared, no irq.
- start in RUN restarts: count<=load, pc<=0, no irq for the aborted period.
- EXPIRED:
  - ack → IDLE with expired<=0.
  - start → RUN directly with expired<=0 (load!=0 rule applies).
- Simultaneous events:
  - stop+start → stop wins.
  - Expiry+stop → stop wins, but irq still pulses for that expiry.
  - ack+expiry in the same cycle → expired ends at 1.
  - cfg_wr+start in the same cycle → start uses the old shadow values.
- Arithmetic: the down-counter never wraps below 0. pc wrap-around at 2^DIV_STAGES is harmless because the tick compares only low tap bits.
- arst mid-RUN: immediate return to reset values; no irq is generated.

Decomposition:
- Package timer_pkg holds:
  - the state enum (IDLE, RUN, EXPIRED);
  - a TAP_W helper function;
  - the tap-mask function (all-ones mask of width tap).
- One sub-module, timer_prescaler:
  - inputs clk, arst, en, clr, tap;
  - outputs pc and tick;
  - it is the enable-gated divider chain.
- FSM, shadow registers and down-counter live in prescale_timer_ctrl.

Test Plan:
- Reset then cfg_wr(tap=2, load=3, one-shot), start → tick every 4 cycles; count 3→2→1→0; irq one cycle at 12 cycles after start; expired=1; busy=0; ack → expired=0.
- Periodic (tap=0, load=5), start, run 20 cycles → irq every 5 cycles, count reloads 5, busy stays 1; stop → IDLE, count frozen, no further irq.
- Start with load=0 → state stays IDLE, busy=0, no tick. Then tap=DIV_STAGES+3 → behaves as tap=DIV_STAGES.
- Mid-run cfg_wr(load=2) during periodic load=4 → current period still 4 ticks, next period 2 ticks. Same-cycle start+stop → IDLE.
- arst asserted asynchronously mid-RUN (between edges) → all outputs 0 immediately; no irq after release until a new start.
- Expiry cycle coinciding with ack (one-shot) → expired=1, irq pulses. Expiry coinciding with stop → irq pulses, state IDLE.
